sfu_acc: RTL and testbench
==========================

# sfu_acc

Special-function/accumulation stage directly downstream of the psum scratch-pad memory in `core`. Each cycle that `acc` is asserted, it adds one psum word (one `psum_bw`-bit partial sum per output channel) read from pmem into per-channel accumulators. After `len_kij` accumulations it presents the ReLU'd result on `sfp_out` with `out_valid`. The block produces `sfp_out` that the bench compares against `out.txt`.

## Interface
- `col`, 8: number of output-channel lanes.
- `psum_bw`, 16: lane width of the psum input, the accumulators and the output.
- `len_kij`, 9: number of accumulations that form one complete output pixel.
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `acc` in 1: accumulate `data_in` this cycle. It is aligned with pmem Q, one cycle after the pmem read request.
- `clear` in 1: synchronous clear of accumulators and count; starts a new output pixel.
- `relu_en` in 1: 1 applies ReLU at the output; 0 passes the accumulator through.
- `data_in` in `col*psum_bw`: psum word; lane k is bits `[psum_bw*(k+1)-1 : psum_bw*k]`, signed two's complement.
- `sfp_out` out `col*psum_bw`: per-lane result, same lane packing as `data_in`.
- `out_valid` out 1: high while the count equals `len_kij`.
- `acc_cnt` out `$clog2(len_kij+1)`: number of accumulations taken since the last reset or clear.
- `acc_err` out 1: sticky flag; set by an `acc` arriving while the count equals `len_kij`.

## Operation
- State per lane:
  - `accum[k]`: signed, `psum_bw` bits.
  - Shared counter `cnt`.
  - Sticky flag `err`.
- Priority each rising edge: `reset` (async) > `clear` > `acc`.
- `clear=1`:
  - Sets all `accum` to 0 and `cnt` to 0.
  - Leaves `err` unchanged.
  - Drops any `acc` asserted in the same cycle; its data is not added.
- `acc=1`, `clear=0`, `cnt<len_kij`:
  - `accum[k] <= accum[k] + data_in[k]` for every lane.
  - Arithmetic is two's complement, modulo 2^`psum_bw` (wrap, no saturation).
  - `cnt <= cnt+1`.
- `acc=1`, `clear=0`, `cnt==len_kij`:
  - Accumulators and `cnt` hold.
  - `err <= 1`.
- `acc=0`, `clear=0`: all state holds.
- Output, combinational from registered state:
  - `relu_en=1`: `sfp_out[k] = accum[k][psum_bw-1] ? 0 : accum[k]`.
  - `relu_en=0`: `sfp_out[k] = accum[k]`.
  - `out_valid = (cnt==len_kij)`.
  - `acc_cnt = cnt`.
- `err` clears only on `reset`.
- No FSM encoding beyond `cnt`. Phases:
  - IDLE: `cnt=0`.
  - ACCUM: `0<cnt<len_kij`.
  - DONE: `cnt=len_kij`.
  - DONE holds until `clear` or `reset`.

## Timing
- Reset values: `sfp_out=0`, `out_valid=0`, `acc_cnt=0`, `acc_err=0`. Outputs change immediately on `reset` assertion, without waiting for a clock.
- Latency: `data_in` sampled with `acc` at edge N affects `sfp_out` right after edge N (one-cycle register latency, no extra pipeline).
- `out_valid` rises after the edge taking the `len_kij`-th `acc` and stays high until `clear` or `reset`.
- `acc` pulses may be non-contiguous; gaps hold state.
- `relu_en` is combinational on the output and may change at any time.
- Reset mid-accumulation: partial sums are discarded; the next `acc` after `reset` deasserts starts at `cnt=0`.
- Bench usage per output pixel:
  - pulse `reset` (or `clear`) for one cycle;
  - issue 9 pmem reads with `acc` trailing by one cycle;
  - sample `sfp_out` once `out_valid` is high.

## Test plan
- **Basic accumulate:** after `reset`, apply 9 `acc` cycles with every lane = 3, `relu_en=1` -> each lane = 27 (0x001B), `out_valid=1`, `acc_cnt=9`, `acc_err=0`.
- **ReLU:**
  - Lane 0 gets -5 ×9 and lane 1 gets +5 ×9; `relu_en=1` -> lane0 = 0, lane1 = 45.
  - Switch to `relu_en=0` -> lane0 = 0xFFD3 (-45).
- **Wrap and overflow:**
  - 9 `acc` of 0x7000 on lane 7 -> lane 7 = (9×0x7000) mod 2^16 = 0xF000.
  - With `relu_en=1` -> lane 7 = 0.
  - A 10th `acc` -> values unchanged, `acc_err=1`, and it stays 1 after a `clear`.
- **Clear vs acc:**
  - `clear` and `acc` (data 7) in the same cycle after 4 accumulations -> `acc_cnt=0`, `sfp_out=0`.
  - Next 9 `acc` of 1 -> 9.
- **Gapped acc and async reset:**
  - 5 `acc` of 2 with idle cycles between -> `acc_cnt=5`, lanes = 10, `out_valid=0`.
  - Assert `reset` mid-cycle -> outputs are 0 before the next clock edge.
- **Integration:** run the kij flow and 16 onij readouts from pmem via `acc_address.txt` -> all 16 `sfp_out` words match `out.txt`.

Source files
------------

// File: rtl/sfu_acc.sv
// Per-lane psum accumulator with a shared accumulation counter and optional ReLU at the output.
// One output pixel is complete after len_kij accepted acc pulses; extra pulses set a sticky error flag.
module sfu_acc #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int len_kij = 9
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             acc,
  input  logic                             clear,
  input  logic                             relu_en,
  input  logic [col*psum_bw-1:0]           data_in,
  output logic [col*psum_bw-1:0]           sfp_out,
  output logic                             out_valid,
  output logic [$clog2(len_kij+1)-1:0]     acc_cnt,
  output logic                             acc_err
);

  localparam int CW = $clog2(len_kij + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(len_kij);

  logic [CW-1:0] cnt_reg;
  logic          err_reg;
  logic          done;
  logic          take;

  assign done = (cnt_reg == CNT_MAX);
  // clear wins over acc, and a finished pixel refuses further data
  assign take = acc && !clear && !done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (acc) begin
      if (done) err_reg <= 1'b1;
      else      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < col; gi++) begin : lane_g
      logic [psum_bw-1:0] accum_reg;

      // modulo-2^psum_bw wrap is intentional; no saturation
      always_ff @(posedge clk or posedge reset) begin
        if (reset)      accum_reg <= '0;
        else if (clear) accum_reg <= '0;
        else if (take)  accum_reg <= accum_reg + data_in[psum_bw*gi +: psum_bw];
      end

      assign sfp_out[psum_bw*gi +: psum_bw] =
        (relu_en && accum_reg[psum_bw-1]) ? '0 : accum_reg;
    end
  endgenerate

  assign out_valid = done;
  assign acc_cnt   = cnt_reg;
  assign acc_err   = err_reg;

endmodule

// File: tb/tb_sfu_acc.sv
// Self-checking bench for sfu_acc: directed test-plan steps followed by randomized pixels
// checked against a full-precision integer model of the per-lane sums.
module tb_sfu_acc;
  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int LEN = 9;
  localparam int W   = COL * BW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          acc = 1'b0;
  logic          clear = 1'b0;
  logic          relu_en = 1'b1;
  logic [W-1:0]  data_in = '0;
  logic [W-1:0]  sfp_out;
  logic          out_valid;
  logic [3:0]    acc_cnt;
  logic          acc_err;

  int checks = 0;
  int errors = 0;

  // reference model: exact integer sums, count of accepted pulses, sticky error
  int m_sum [COL];
  int m_cnt;
  bit m_err;

  sfu_acc #(.col(COL), .psum_bw(BW), .len_kij(LEN)) dut (
    .clk(clk), .reset(reset), .acc(acc), .clear(clear), .relu_en(relu_en),
    .data_in(data_in), .sfp_out(sfp_out), .out_valid(out_valid),
    .acc_cnt(acc_cnt), .acc_err(acc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_out(input logic relu);
    logic [W-1:0] r;
    logic signed [BW-1:0] w;
    r = '0;
    for (int k = 0; k < COL; k++) begin
      w = m_sum[k][BW-1:0];
      if (relu && w < 0) w = '0;
      r[k*BW +: BW] = w;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] all_lanes(input logic [BW-1:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < COL; k++) r[k*BW +: BW] = v;
    return r;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_sfp"}, sfp_out, model_out(relu_en));
    chk({tag, "_valid"}, W'(out_valid), W'(m_cnt == LEN));
    chk({tag, "_cnt"}, W'(acc_cnt), W'(m_cnt));
    chk({tag, "_err"}, W'(acc_err), W'(m_err));
  endtask

  task automatic model_reset();
    for (int k = 0; k < COL; k++) m_sum[k] = 0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  // one clock cycle with the given controls; inputs change 1 time unit after the edge
  task automatic step(input logic a, input logic c, input logic [W-1:0] d);
    logic signed [BW-1:0] lane;
    acc = a; clear = c; data_in = d;
    @(posedge clk);
    if (c) begin
      for (int k = 0; k < COL; k++) m_sum[k] = 0;
      m_cnt = 0;
    end else if (a) begin
      if (m_cnt < LEN) begin
        for (int k = 0; k < COL; k++) begin
          lane = d[k*BW +: BW];
          m_sum[k] = m_sum[k] + lane;
        end
        m_cnt++;
      end else begin
        m_err = 1'b1;
      end
    end
    #1;
    acc = 1'b0; clear = 1'b0; data_in = '0;
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
    model_reset();
    chk("reset_async_sfp", sfp_out, '0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] d;
    model_reset();

    // reset state
    do_reset();
    check_model("reset");
    chk("reset_valid", W'(out_valid), '0);

    // basic accumulate: 9 x 3 on all lanes
    relu_en = 1'b1;
    for (int i = 0; i < LEN; i++) begin
      step(1'b1, 1'b0, all_lanes(16'd3));
      if (i == 0) chk("latency_first", sfp_out, all_lanes(16'd3));
    end
    chk("basic_sfp", sfp_out, all_lanes(16'h001B));
    chk("basic_valid", W'(out_valid), W'(1));
    chk("basic_cnt", W'(acc_cnt), W'(9));
    chk("basic_err", W'(acc_err), W'(0));
    $display("basic: sfp=%h cnt=%0d", sfp_out, acc_cnt);

    // ReLU: lane0 -5, lane1 +5
    step(1'b0, 1'b1, '0);
    d = '0; d[15:0] = -16'sd5; d[31:16] = 16'd5;
    for (int i = 0; i < LEN; i++) step(1'b1, 1'b0, d);
    chk("relu_lane0", W'(sfp_out[15:0]), W'(0));
    chk("relu_lane1", W'(sfp_out[31:16]), W'(45));
    relu_en = 1'b0; #1;
    chk("norelu_lane0", W'(sfp_out[15:0]), W'(16'hFFD3));
    check_model("relu");
    $display("relu: lane0=%h lane1=%h", sfp_out[15:0], sfp_out[31:16]);

    // wrap on lane 7
    step(1'b0, 1'b1, '0);
    d = '0; d[127:112] = 16'h7000;
    for (int i = 0; i < LEN; i++) step(1'b1, 1'b0, d);
    chk("wrap_lane7", W'(sfp_out[127:112]), W'(16'hF000));
    relu_en = 1'b1; #1;
    chk("wrap_relu_lane7", W'(sfp_out[127:112]), W'(0));
    step(1'b1, 1'b0, d);
    chk("overflow_err", W'(acc_err), W'(1));
    chk("overflow_cnt", W'(acc_cnt), W'(9));
    check_model("overflow");
    step(1'b0, 1'b1, '0);
    chk("err_sticky_clear", W'(acc_err), W'(1));
    $display("wrap: err=%0d after clear", acc_err);

    // clear and acc together after 4 accumulations
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, all_lanes(16'd2));
    step(1'b1, 1'b1, all_lanes(16'd7));
    chk("clr_acc_cnt", W'(acc_cnt), W'(0));
    chk("clr_acc_sfp", sfp_out, '0);
    for (int i = 0; i < LEN; i++) step(1'b1, 1'b0, all_lanes(16'd1));
    chk("after_clear_sfp", sfp_out, all_lanes(16'd9));
    check_model("after_clear");
    $display("clear_vs_acc: sfp=%h", sfp_out);

    // gapped acc then async reset mid-cycle
    step(1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, all_lanes(16'd2));
      step(1'b0, 1'b0, all_lanes(16'hFFFF));
      step(1'b0, 1'b0, '0);
    end
    chk("gap_cnt", W'(acc_cnt), W'(5));
    chk("gap_sfp", sfp_out, all_lanes(16'd10));
    chk("gap_valid", W'(out_valid), W'(0));
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("midreset_sfp", sfp_out, '0);
    chk("midreset_cnt", W'(acc_cnt), W'(0));
    chk("midreset_err", W'(acc_err), W'(0));
    @(posedge clk); #1 reset = 1'b0;
    step(1'b1, 1'b0, all_lanes(16'd4));
    chk("post_reset_cnt", W'(acc_cnt), W'(1));
    $display("gap_reset: cnt=%0d sfp=%h", acc_cnt, sfp_out);

    // randomized pixels: random data, gaps, extra pulses, occasional clears, relu toggles
    for (int p = 0; p < 24; p++) begin
      step(1'b0, 1'b1, '0);
      check_model("rnd_clear");
      while (m_cnt < LEN) begin
        for (int k = 0; k < COL; k++)
          d[k*BW +: BW] = ($urandom_range(0, 1) == 1) ? BW'($urandom) : BW'($urandom_range(0, 20) - 10);
        step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, d);
        relu_en = $urandom_range(0, 1) == 1;
        #1;
        check_model("rnd");
      end
      if ($urandom_range(0, 2) == 0) begin
        step(1'b1, 1'b0, all_lanes(BW'($urandom)));
        check_model("rnd_extra");
      end
      $display("pixel %0d: sfp=%h relu=%0d err=%0d", p, sfp_out, relu_en, acc_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
